// File: rtl/mic_sample_scheduler.sv
// Paces PmodMIC conversions at a fixed sample rate and reduces each window of
// offset-binary samples to a peak magnitude offered over valid/ready.
module mic_sample_scheduler #(
    parameter int SAMPLE_DIV = 250,
    parameter int WINDOW     = 1024,
    parameter int TIMEOUT    = 40,
    parameter int DATA_W     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic [DATA_W-1:0] peak,
    output logic              peak_valid,
    input  logic              peak_ready,
    output logic              err_overrun,
    output logic              err_timeout,
    output logic              err_drop,
    input  logic              clr_err
);

    localparam int CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W:0] MID = {2'b01, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, WAIT, START, CONV, ACCUM, PUBLISH} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  rate_cnt;
    logic              tick;
    logic [TMR_W-1:0]  timer;
    logic [WIN_W-1:0]  win_cnt;
    logic [DATA_W-1:0] mag_p1;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_nxt;
    logic              vld_p1;
    logic              win_last;
    logic              publish;
    logic              busy;
    logic              ovr_ev;
    logic              to_ev;
    logic              drop_ev;

    // Distance from mid-scale, computed one bit wider so 0x000 maps to 2048.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] raw);
        logic [DATA_W:0] wide;
        logic [DATA_W:0] diff;
        wide = {1'b0, raw};
        diff = (wide >= MID) ? (wide - MID) : (MID - wide);
        return DATA_W'(diff);
    endfunction

    always_ff @(posedge clk) begin
        if (reset || !enable || tick) begin
            rate_cnt <= '0;
        end else begin
            rate_cnt <= rate_cnt + 1'b1;
        end
    end

    assign tick      = (rate_cnt == CNT_W'(SAMPLE_DIV - 1));
    assign adc_start = (state == START);
    assign win_last  = (win_cnt == WIN_W'(WINDOW - 1));
    assign acc_nxt   = (mag_p1 > acc) ? mag_p1 : acc;
    // The window result is registered on entry to PUBLISH so it is already
    // visible during PUBLISH, two cycles after the final adc_done.
    assign publish   = (state == ACCUM) && win_last;
    assign busy      = (state == START) || (state == CONV) || (state == ACCUM) || (state == PUBLISH);
    assign ovr_ev    = tick && busy;
    assign to_ev     = (state == CONV) && !adc_done && (timer == TMR_W'(TIMEOUT));
    assign drop_ev   = publish && peak_valid && !peak_ready;
    assign vld_p1    = (state == CONV) && adc_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = WAIT;
            WAIT: begin
                if (!enable)   state_nxt = IDLE;
                else if (tick) state_nxt = START;
            end
            START:   state_nxt = CONV;
            CONV: begin
                if (adc_done)   state_nxt = ACCUM;
                else if (to_ev) state_nxt = WAIT;
            end
            ACCUM: begin
                if (win_last)    state_nxt = PUBLISH;
                else if (enable) state_nxt = WAIT;
                else             state_nxt = IDLE;
            end
            PUBLISH: state_nxt = enable ? WAIT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: magnitude of the sample captured on adc_done.
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            mag_p1 <= magnitude(adc_data);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer       <= '0;
            acc         <= '0;
            win_cnt     <= '0;
            peak        <= '0;
            peak_valid  <= 1'b0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
            err_drop    <= 1'b0;
        end else begin
            if (state == START) begin
                timer <= TMR_W'(1);
            end else if (state == CONV) begin
                timer <= timer + 1'b1;
            end

            if (state == ACCUM) begin
                acc     <= win_last ? '0 : acc_nxt;
                win_cnt <= win_last ? '0 : win_cnt + 1'b1;
            end

            if (publish) begin
                if (!drop_ev) begin
                    peak       <= acc_nxt;
                    peak_valid <= 1'b1;
                end
            end else if (peak_valid && peak_ready) begin
                peak_valid <= 1'b0;
            end

            // A new error event outranks a simultaneous clear.
            err_overrun <= ovr_ev  || (err_overrun && !clr_err);
            err_timeout <= to_ev   || (err_timeout && !clr_err);
            err_drop    <= drop_ev || (err_drop    && !clr_err);
        end
    end

endmodule

// File: tb/tb_mic_sample_scheduler.sv
// Randomized bench for mic_sample_scheduler: a cycle-indexed schedule model
// predicts starts, flags and window peaks; a monitor scores peak transfers.
module tb_mic_sample_scheduler;

    localparam int DIV = 40;
    localparam int WIN = 4;
    localparam int TMO = 40;
    localparam int DW  = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          adc_start;
    logic          adc_done = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic [DW-1:0] peak;
    logic          peak_valid;
    logic          peak_ready = 1'b0;
    logic          err_overrun;
    logic          err_timeout;
    logic          err_drop;
    logic          clr_err = 1'b0;

    int total = 0;
    int bad   = 0;
    int q_peak[$];

    mic_sample_scheduler #(
        .SAMPLE_DIV(DIV), .WINDOW(WIN), .TIMEOUT(TMO), .DATA_W(DW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
        .peak(peak), .peak_valid(peak_valid), .peak_ready(peak_ready),
        .err_overrun(err_overrun), .err_timeout(err_timeout), .err_drop(err_drop),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scores every peak the consumer accepts against the model's queue.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && peak_valid && peak_ready) begin
                if (q_peak.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL peak_transfer: got %0d, expected no pending result", peak);
                end else begin
                    check("peak_value", int'(peak), q_peak.pop_front());
                end
            end
        end
    end

    initial begin
        int tbl[12] = '{2048, 2148, 1848, 2050, 0, 4095, 2048, 2048, 2048, 2048, 2048, 2048};
        int exp_start = -1, done_cyc = -1, to_cyc = -1, pub_cyc = -1, busy_until = -1;
        int reset_cyc = -1, clr_cyc = -1, en_lo_from = -1, en_lo_to = -1;
        int conv_k = 0, run_start = 0, d = 0, s = 0, mag = 0;
        int wacc = 0, wcnt = 0, cur_peak = 0, pub_val = 0, conv_data = 0;
        bit prev_en = 1'b0, pending = 1'b0, done_ok = 1'b0, finished = 1'b0;
        bit e_ovr = 1'b0, e_to = 1'b0, e_drop = 1'b0;
        bit ev_ovr, ev_to, ev_drop, tick;

        repeat (3) @(negedge clk);
        check("rst_adc_start", int'(adc_start), 0);
        check("rst_peak", int'(peak), 0);
        check("rst_peak_valid", int'(peak_valid), 0);
        check("rst_err_overrun", int'(err_overrun), 0);
        check("rst_err_timeout", int'(err_timeout), 0);
        check("rst_err_drop", int'(err_drop), 0);

        for (int c = 0; c < 4000 && !finished; c++) begin
            if (c > 0) @(negedge clk);

            if (reset_cyc >= 0 && c == reset_cyc + 1) begin
                check("midrst_adc_start", int'(adc_start), 0);
                check("midrst_peak", int'(peak), 0);
                check("midrst_peak_valid", int'(peak_valid), 0);
                check("midrst_err_overrun", int'(err_overrun), 0);
                check("midrst_err_timeout", int'(err_timeout), 0);
                check("midrst_err_drop", int'(err_drop), 0);
                q_peak.delete();
                finished = 1'b1;
            end else begin
                // Outputs of cycle c against the model state carried from c-1.
                check("adc_start", int'(adc_start), int'(c == exp_start));
                check("peak_valid", int'(peak_valid), int'(pending));
                if (pending) check("peak_hold", int'(peak), cur_peak);
                check("err_overrun", int'(err_overrun), int'(e_ovr));
                check("err_timeout", int'(err_timeout), int'(e_to));
                check("err_drop", int'(err_drop), int'(e_drop));

                // Inputs for cycle c.
                reset      = (c == reset_cyc);
                enable     = !(c >= en_lo_from && c <= en_lo_to);
                adc_done   = (c == done_cyc);
                adc_data   = (c == done_cyc) ? DW'(conv_data) : DW'($urandom_range(0, 4095));
                clr_err    = (c == clr_cyc);
                if (conv_k < 18)       peak_ready = 1'b1;
                else if (conv_k <= 29) peak_ready = 1'b0;
                else                   peak_ready = ($urandom_range(0, 3) != 0);

                // Events during cycle c.
                ev_ovr = 1'b0;
                ev_to = 1'b0;
                ev_drop = 1'b0;
                if (!prev_en) run_start = c;
                tick = (((c - run_start) % DIV) == DIV - 1);
                if (tick) begin
                    if (c <= busy_until) begin
                        ev_ovr = 1'b1;
                    end else begin
                        s = c + 1;
                        exp_start = s;
                        if (conv_k == 12 || conv_k == 31)                      d = 50;
                        else if (conv_k == 14 || conv_k == 23 || conv_k == 38) d = 39;
                        else if (conv_k == 26)                                 d = 40;
                        else if (conv_k == 34)                                 d = 5;
                        else if (conv_k == 48)                                 d = 1000;
                        else                                                   d = $urandom_range(1, 20);
                        if (conv_k < 12)           conv_data = tbl[conv_k];
                        else if (conv_k % 5 == 0)  conv_data = (conv_k % 2 == 1) ? 0 : 4095;
                        else                       conv_data = $urandom_range(0, 4095);
                        if (conv_k == 34) begin
                            en_lo_from = s + 2;
                            en_lo_to   = s + 31;
                        end
                        if (conv_k == 48) reset_cyc = s + 3;
                        if (d == 39) clr_cyc = s + 39;
                        else if (conv_k == 16 || conv_k == 33) clr_cyc = s + 10;
                        done_cyc = s + d;
                        done_ok  = (d <= TMO);
                        if (done_ok) begin
                            to_cyc = -1;
                            busy_until = s + d + 1 + ((wcnt == WIN - 1) ? 1 : 0);
                        end else begin
                            to_cyc = s + TMO;
                            busy_until = s + TMO;
                        end
                        conv_k++;
                    end
                end
                if (c == to_cyc) ev_to = 1'b1;
                if (c == done_cyc && done_ok) begin
                    mag = (conv_data >= 2048) ? conv_data - 2048 : 2048 - conv_data;
                    if (mag > wacc) wacc = mag;
                    wcnt++;
                    if (wcnt == WIN) begin
                        pub_cyc = c + 1;
                        pub_val = wacc;
                        wacc = 0;
                        wcnt = 0;
                    end
                end
                if (c == pub_cyc) begin
                    if (pending && !peak_ready) begin
                        ev_drop = 1'b1;
                    end else begin
                        pending  = 1'b1;
                        cur_peak = pub_val;
                        q_peak.push_back(pub_val);
                    end
                end else if (pending && peak_ready) begin
                    pending = 1'b0;
                end
                if (clr_err) begin
                    e_ovr = ev_ovr;
                    e_to = ev_to;
                    e_drop = ev_drop;
                end else begin
                    e_ovr  = e_ovr  | ev_ovr;
                    e_to   = e_to   | ev_to;
                    e_drop = e_drop | ev_drop;
                end
                prev_en = enable;
            end
        end

        if (!finished) begin
            total++;
            bad++;
            $display("FAIL run_limit: got %0d conversions, expected schedule to reach 49", conv_k);
        end
        reset = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
